// File: rtl/melody_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | melody_sequencer: steps a song ROM and drives timed note IDs to the synth |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module melody_sequencer #(
   parameter int TICK_DIV  = 312500,
   parameter int SONG_LEN  = 32,
   parameter int ADDR_W    = 5,
   parameter int GAP_TICKS = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [3:0]        note,
   output logic              busy,
   output logic              beat,
   output logic              song_done
);

   localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int GC_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

   localparam logic [PS_W-1:0]   c_PS_MAX    = PS_W'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(SONG_LEN - 1);
   localparam logic [GC_W-1:0]   c_GAP_INIT  = GC_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
   localparam logic [7:0]        c_END_MARK  = 8'hFF;

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_FETCH = 3'd1;
   localparam logic [2:0] c_LOAD  = 3'd2;
   localparam logic [2:0] c_PLAY  = 3'd3;
   localparam logic [2:0] c_GAP   = 3'd4;

   logic [2:0]        r_state;
   logic [PS_W-1:0]   r_ps;
   logic [3:0]        r_dur;
   logic [GC_W-1:0]   r_gap;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_note;
   logic [3:0]        r_note_out;
   logic              r_done;

   logic [2:0]        w_state_n;
   logic [PS_W-1:0]   w_ps_n;
   logic [3:0]        w_dur_n;
   logic [GC_W-1:0]   w_gap_n;
   logic [ADDR_W-1:0] w_addr_n;
   logic [3:0]        w_note_n;
   logic              w_done_n;
   logic              w_adv;
   logic              w_run;
   logic              w_tick;
   logic              w_mute;

   assign w_run  = ((r_state == c_PLAY) || (r_state == c_GAP)) && !pause;
   assign w_tick = w_run && (r_ps == c_PS_MAX);

   always_comb begin
      w_state_n = r_state;
      w_ps_n    = r_ps;
      w_dur_n   = r_dur;
      w_gap_n   = r_gap;
      w_addr_n  = r_addr;
      w_note_n  = r_note;
      w_done_n  = 1'b0;
      w_adv     = 1'b0;

      case (r_state)
         c_IDLE: begin
            w_addr_n = '0;
            w_note_n = 4'd0;
            if (play) begin
               w_state_n = c_FETCH;
            end
         end
         c_FETCH: begin
            w_state_n = c_LOAD;
         end
         c_LOAD: begin
            if (rom_data == c_END_MARK) begin
               // A marker at entry 0 would loop forever without ever sounding
               if (loop && (r_addr != '0)) begin
                  w_addr_n  = '0;
                  w_state_n = c_FETCH;
               end else begin
                  w_addr_n  = '0;
                  w_note_n  = 4'd0;
                  w_done_n  = 1'b1;
                  w_state_n = c_IDLE;
               end
            end else begin
               w_note_n  = (rom_data[7:4] >= 4'd13) ? 4'd0 : rom_data[7:4];
               w_dur_n   = rom_data[3:0];
               w_ps_n    = '0;
               w_state_n = c_PLAY;
            end
         end
         c_PLAY: begin
            if (w_run) begin
               if (w_tick) begin
                  w_ps_n = '0;
                  if (r_dur != 4'd0) begin
                     w_dur_n = r_dur - 4'd1;
                  end else if (GAP_TICKS > 0) begin
                     w_note_n  = 4'd0;
                     w_gap_n   = c_GAP_INIT;
                     w_state_n = c_GAP;
                  end else begin
                     w_adv = 1'b1;
                  end
               end else begin
                  w_ps_n = r_ps + PS_W'(1);
               end
            end
         end
         c_GAP: begin
            if (w_run) begin
               if (w_tick) begin
                  w_ps_n = '0;
                  if (r_gap != '0) begin
                     w_gap_n = r_gap - GC_W'(1);
                  end else begin
                     w_adv = 1'b1;
                  end
               end else begin
                  w_ps_n = r_ps + PS_W'(1);
               end
            end
         end
         default: begin
            w_state_n = c_IDLE;
         end
      endcase

      // Loop is sampled here, at the moment the song runs off its last entry
      if (w_adv) begin
         if (r_addr == c_ADDR_LAST) begin
            w_addr_n = '0;
            if (loop) begin
               w_state_n = c_FETCH;
            end else begin
               w_note_n  = 4'd0;
               w_done_n  = 1'b1;
               w_state_n = c_IDLE;
            end
         end else begin
            w_addr_n  = r_addr + ADDR_W'(1);
            w_state_n = c_FETCH;
         end
      end

      if (stop) begin
         w_state_n = c_IDLE;
         w_addr_n  = '0;
         w_note_n  = 4'd0;
         w_done_n  = 1'b0;
         w_ps_n    = '0;
         w_dur_n   = 4'd0;
         w_gap_n   = '0;
      end
   end

   // The stored note survives a pause; only the driven copy is muted
   assign w_mute = pause && ((w_state_n == c_PLAY) || (w_state_n == c_GAP));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_ps       <= '0;
         r_dur      <= 4'd0;
         r_gap      <= '0;
         r_addr     <= '0;
         r_note     <= 4'd0;
         r_note_out <= 4'd0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_ps       <= w_ps_n;
         r_dur      <= w_dur_n;
         r_gap      <= w_gap_n;
         r_addr     <= w_addr_n;
         r_note     <= w_note_n;
         r_note_out <= w_mute ? 4'd0 : w_note_n;
         r_done     <= w_done_n;
      end
   end

   assign rom_addr  = r_addr;
   assign note      = r_note_out;
   assign busy      = (r_state != c_IDLE);
   assign beat      = w_tick && !stop && !reset;
   assign song_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_melody_sequencer: scoreboard bench, per-cycle expected output queues   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_melody_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, play, stop, pause, loop;

   logic [4:0] addr0;
   logic [7:0] rd0;
   logic [3:0] note0;
   logic       busy0, beat0, done0;
   logic [1:0] addr1;
   logic [7:0] rd1;
   logic [3:0] note1;
   logic       busy1, beat1, done1;

   logic [7:0] rom0 [0:31];
   logic [7:0] rom1 [0:3];

   always_ff @(posedge clk) rd0 <= rom0[addr0];
   always_ff @(posedge clk) rd1 <= rom1[addr1];

   melody_sequencer #(.TICK_DIV(4), .SONG_LEN(32), .ADDR_W(5), .GAP_TICKS(0)) dut0 (
      .clk(clk), .reset(reset), .play(play), .stop(stop), .pause(pause), .loop(loop),
      .rom_addr(addr0), .rom_data(rd0), .note(note0), .busy(busy0), .beat(beat0),
      .song_done(done0)
   );

   melody_sequencer #(.TICK_DIV(4), .SONG_LEN(4), .ADDR_W(2), .GAP_TICKS(1)) dut1 (
      .clk(clk), .reset(reset), .play(play), .stop(stop), .pause(pause), .loop(loop),
      .rom_addr(addr1), .rom_data(rd1), .note(note1), .busy(busy1), .beat(beat1),
      .song_done(done1)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [3:0] note;
      logic       busy;
      logic       beat;
      logic       done;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   idx0 = 0;
   int   idx1 = 0;
   exp_t e0, e1;

   // Expected-trace scratch arrays, indexed by cycle relative to the play pulse
   int x_note [0:63];
   bit x_busy [0:63];
   bit x_beat [0:63];
   bit x_done [0:63];

   always @(negedge clk) begin
      if (q0.size() > 0) begin
         e0 = q0.pop_front();
         chk($sformatf("d0 c%0d note", idx0), note0, e0.note);
         chk($sformatf("d0 c%0d busy", idx0), busy0, e0.busy);
         chk($sformatf("d0 c%0d beat", idx0), beat0, e0.beat);
         chk($sformatf("d0 c%0d song_done", idx0), done0, e0.done);
         idx0++;
      end
      if (q1.size() > 0) begin
         e1 = q1.pop_front();
         chk($sformatf("d1 c%0d note", idx1), note1, e1.note);
         chk($sformatf("d1 c%0d busy", idx1), busy1, e1.busy);
         chk($sformatf("d1 c%0d beat", idx1), beat1, e1.beat);
         chk($sformatf("d1 c%0d song_done", idx1), done1, e1.done);
         idx1++;
      end
   end

   task automatic exp_clear();
      for (int i = 0; i < 64; i++) begin
         x_note[i] = 0;
         x_busy[i] = 1'b0;
         x_beat[i] = 1'b0;
         x_done[i] = 1'b0;
      end
   endtask

   task automatic exp_note(input int a, input int b, input int v);
      for (int i = a; i <= b; i++) x_note[i] = v;
   endtask

   task automatic exp_busy(input int a, input int b);
      for (int i = a; i <= b; i++) x_busy[i] = 1'b1;
   endtask

   task automatic exp_commit(input int which, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.note = 4'(x_note[i]);
         e.busy = x_busy[i];
         e.beat = x_beat[i];
         e.done = x_done[i];
         if (which == 0) q0.push_back(e);
         else            q1.push_back(e);
      end
      if (which == 0) idx0 = 0;
      else            idx1 = 0;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int budget = 300;
      while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("drain_pending", q0.size() + q1.size(), 0);
      cyc(4);
   endtask

   task automatic rom_fill_ff();
      for (int i = 0; i < 32; i++) rom0[i] = 8'hFF;
      for (int i = 0; i < 4; i++)  rom1[i] = 8'hFF;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; play = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
      rom_fill_ff();
      cyc(2);
      @(negedge clk);
      chk("rst note0", note0, 0);
      chk("rst addr0", addr0, 0);
      chk("rst busy0", busy0, 0);
      chk("rst beat0", beat0, 0);
      chk("rst done0", done0, 0);
      chk("rst note1", note1, 0);
      chk("rst busy1", busy1, 0);
      cyc(1);
      reset = 1'b0;
      cyc(2);

      // stop together with play in IDLE keeps the sequencer idle
      exp_clear();
      play = 1'b1; stop = 1'b1;
      exp_commit(0, 5);
      cyc(1);
      play = 1'b0; stop = 1'b0;
      drain();

      // loop=1: marker at entry 2 returns to entry 0; stop 2 cycles after note=1 returns
      rom0[0] = 8'h13; rom0[1] = 8'hA0; rom0[2] = 8'hFF;
      exp_clear();
      exp_note(3, 20, 1); exp_note(21, 28, 10); exp_note(29, 31, 1);
      exp_busy(1, 31);
      x_beat[6] = 1; x_beat[10] = 1; x_beat[14] = 1; x_beat[18] = 1; x_beat[24] = 1;
      loop = 1'b1; play = 1'b1;
      exp_commit(0, 36);
      cyc(1);
      play = 1'b0;
      cyc(30);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      @(negedge clk);
      chk("stop addr0", addr0, 0);
      drain();

      // loop=0: restart from entry 0 to a natural end; dut1 plays two gapped notes
      rom1[0] = 8'h50; rom1[1] = 8'h50; rom1[2] = 8'hFF; rom1[3] = 8'hFF;
      exp_clear();
      exp_note(3, 20, 1); exp_note(21, 26, 10);
      exp_busy(1, 26);
      x_beat[6] = 1; x_beat[10] = 1; x_beat[14] = 1; x_beat[18] = 1; x_beat[24] = 1;
      x_done[27] = 1;
      loop = 1'b0; play = 1'b1;
      exp_commit(0, 30);
      exp_clear();
      exp_note(3, 6, 5); exp_note(13, 16, 5);
      exp_busy(1, 22);
      x_beat[6] = 1; x_beat[10] = 1; x_beat[16] = 1; x_beat[20] = 1;
      x_done[23] = 1;
      exp_commit(1, 26);
      cyc(1);
      play = 1'b0;
      drain();
      chk("end addr0", addr0, 0);
      rom_fill_ff();

      // pause for 10 cycles in the middle of a one-tick note
      rom0[0] = 8'h30; rom0[1] = 8'hFF;
      exp_clear();
      exp_note(3, 4, 3); exp_note(15, 18, 3);
      exp_busy(1, 18);
      x_beat[16] = 1;
      x_done[19] = 1;
      play = 1'b1;
      exp_commit(0, 23);
      cyc(1);
      play = 1'b0;
      cyc(3);
      pause = 1'b1;
      cyc(10);
      pause = 1'b0;
      drain();

      // end marker at entry 0 never loops
      rom0[0] = 8'hFF;
      exp_clear();
      exp_busy(1, 2);
      x_done[3] = 1;
      loop = 1'b1; play = 1'b1;
      exp_commit(0, 9);
      cyc(1);
      play = 1'b0;
      drain();

      // dut1: four gapped notes with no marker, loop=0 ends at the address wrap
      rom1[0] = 8'h10; rom1[1] = 8'h20; rom1[2] = 8'h30; rom1[3] = 8'h40;
      exp_clear();
      for (int k = 0; k < 4; k++) begin
         exp_note(3 + 10 * k, 6 + 10 * k, k + 1);
         x_beat[6 + 10 * k]  = 1;
         x_beat[10 + 10 * k] = 1;
      end
      exp_busy(1, 40);
      x_done[41] = 1;
      loop = 1'b0; play = 1'b1;
      exp_commit(1, 45);
      cyc(1);
      play = 1'b0;
      drain();
      rom_fill_ff();

      // reset in the middle of a note clears everything the next cycle
      rom0[0] = 8'h13; rom0[1] = 8'hA0; rom0[2] = 8'hFF;
      exp_clear();
      exp_note(3, 8, 1);
      exp_busy(1, 8);
      x_beat[6] = 1;
      play = 1'b1;
      exp_commit(0, 12);
      cyc(1);
      play = 1'b0;
      cyc(7);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      @(negedge clk);
      chk("reset-mid addr0", addr0, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Plays a song held in a small external synchronous ROM. It steps through the entries and drives the 4-bit note ID consumed by the note frequency synthesizer; each note is held for a programmed number of beat ticks. The sequencer supports play/stop/pause, an optional articulation gap between notes, and looping. It sits between the top-level button/switch logic and the note synthesizer, in the 5 MHz clock domain.

Parameters:
TICK_DIV, 312500, clocks per beat tick (62.5 ms at 5 MHz); minimum 2.
SONG_LEN, 32, number of ROM entries; the address wraps at SONG_LEN-1.
ADDR_W, 5, width of rom_addr; must satisfy 2^ADDR_W >= SONG_LEN.
GAP_TICKS, 0, silent ticks inserted after each note (0 = legato).

Ports:
clk  input  1  system clock, 5 MHz
reset  input  1  synchronous, active-high reset
play  input  1  start pulse; sampled only in IDLE
stop  input  1  abort pulse; any state; has priority over play and pause
pause  input  1  level; freezes timing and mutes output while high
loop  input  1  level; 1 = restart at entry 0 on end marker or address wrap
rom_addr  output  ADDR_W  ROM address (registered)
rom_data  input  8  ROM data, valid one clock after rom_addr; [7:4] note ID, [3:0] duration-1 in ticks
note  output  4  note ID to synthesizer (0 = silence; registered)
busy  output  1  high in every state except IDLE
beat  output  1  one-clock pulse per tick while in PLAY/GAP
song_done  output  1  one-clock pulse when playback ends naturally

Behaviour:
- Reset (synchronous, active-high) forces: state=IDLE, note=0, rom_addr=0, busy=0, beat=0, song_done=0; prescaler, duration and gap counters = 0.
- States are IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE:
  - note=0 and rom_addr=0.
  - play=1 (with stop=0) → FETCH.
  - play in any other state is ignored.
- FETCH: one cycle; rom_addr is presented → LOAD.
- LOAD (rom_data valid):
  - End marker is 8'hFF.
    - If loop=1 and rom_addr!=0: rom_addr←0, go to FETCH.
    - Otherwise: go to IDLE and pulse song_done (marker at address 0 never loops).
  - Any other entry: note←[7:4], except IDs 13..15 become 0 (rest); dur_cnt←[3:0]; prescaler←0; go to PLAY.
- PLAY:
  - The prescaler counts 0..TICK_DIV-1; the tick is the cycle where it equals TICK_DIV-1, and beat=1 on that cycle.
  - On a tick with dur_cnt!=0: dur_cnt decrements.
  - On a tick with dur_cnt=0:
    - If GAP_TICKS>0: go to GAP with note←0, prescaler←0, gap counter←GAP_TICKS-1.
    - Otherwise: advance the address and go to FETCH.
  - Time spent in PLAY is exactly (dur+1)*TICK_DIV clocks.
- GAP: counts ticks like PLAY with note=0; when the gap counter reaches 0 on a tick, advance the address and go to FETCH.
- Address advance:
  - rom_addr+1 normally.
  - At SONG_LEN-1: if loop=1, wrap to 0 and go to FETCH; if loop=0, go to IDLE and pulse song_done.
- note changes only on entry to PLAY (new value), entry to GAP (0), or entry to IDLE (0). During FETCH/LOAD after PLAY, note holds the previous value, so there is no glitch between legato notes.
- Latency: play sampled at cycle t → FETCH t+1 → LOAD t+2 → note valid at t+3.
- Pause:
  - While pause=1 in PLAY/GAP, the prescaler and counters freeze, beat=0 and the note output is forced to 0. The stored note is kept.
  - On release, the stored note is restored next cycle and counting resumes from the frozen value.
  - In FETCH/LOAD, pause takes effect on entry to PLAY.
  - pause has no effect in IDLE.
- stop=1 in any state: next cycle IDLE, note=0, rom_addr=0, no song_done. stop with play in IDLE: stays IDLE.
- song_done and beat never assert in the same cycle as reset or stop.
- The loop input is sampled at the moment of decision (LOAD or address advance), not at play.

Test Plan:
- TICK_DIV=4, GAP=0, ROM {0x13, 0xA0, 0xFF}, play at cycle 0 → note=1 for cycles 3..20, note=10 for cycles 21..26, note=0 and song_done=1 at cycle 27, busy low from 27; beat pulses at cycles 6, 10, 14, 18, 24.
- Same ROM with loop=1 → after the entry-1 note, rom_addr returns to 0 and note=1 reappears 3 cycles after the FF is loaded; no song_done.
- GAP_TICKS=1, ROM {0x50, 0x50, 0xFF} → note=5 for 4 clocks, note=0 for 4+2 clocks, note=5 again; the two notes are never merged.
- ROM entry 0x30 (D, 1 tick), pause high for 10 cycles mid-note → note=0 during pause, total PLAY time = 4+10 clocks, note=3 resumes.
- stop asserted 2 cycles after note=1 appears → note=0, rom_addr=0, busy=0 the next cycle, no song_done; a subsequent play restarts at entry 0.
- ROM[0]=0xFF with loop=1 → IDLE at cycle 3, song_done pulse, no infinite loop; reset mid-PLAY → all outputs 0 the next cycle.
